// File: rtl/random_delay_generator_pkg.sv
// Shared constants for the pseudo-random back-pressure generator: LFSR taps and defaults.
package random_delay_generator_pkg;

    localparam int unsigned LFSR_W_DEFAULT     = 8;
    localparam logic [7:0]  SEED_DEFAULT       = 8'h01;
    localparam int unsigned DELAY_BITS_DEFAULT = 3;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
    localparam int unsigned TAP_0 = 7;
    localparam int unsigned TAP_1 = 5;
    localparam int unsigned TAP_2 = 4;
    localparam int unsigned TAP_3 = 3;

    function automatic logic lfsr_fb(logic [7:0] s);
        return s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
    endfunction

endpackage

// File: rtl/random_delay_generator_mux_key.sv
// Generic key->data lookup: OR of the data fields of every lut pair whose key matches.
module mux_key #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                out,
    input  logic [KEY_LEN-1:0]                 key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

    localparam int unsigned P = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] masked [NR_KEY];

    for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
        logic [KEY_LEN-1:0]  pair_key;
        logic [DATA_LEN-1:0] pair_data;
        assign pair_key   = lut[i*P + DATA_LEN +: KEY_LEN];
        assign pair_data  = lut[i*P +: DATA_LEN];
        assign masked[i]  = pair_data & {DATA_LEN{pair_key == key}};
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            out = out | masked[i];
        end
    end

endmodule

// File: rtl/random_delay_generator.sv
// Pseudo-random one-bit back-pressure source: LFSR-loaded down-counter, trigger when it is zero.
module random_delay_generator
    import random_delay_generator_pkg::*;
#(
    parameter int unsigned       LFSR_W     = LFSR_W_DEFAULT,
    parameter logic [LFSR_W-1:0] SEED       = SEED_DEFAULT,
    parameter int unsigned       DELAY_BITS = DELAY_BITS_DEFAULT,
    parameter bit                ENABLE     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    output logic delay_trigger
);

    // An all-zero LFSR would lock up, so an illegal zero seed falls back to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
    logic [DELAY_BITS-1:0] cnt_q, cnt_d;
    logic                  cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q)};
        cnt_d  = cnt_zero ? lfsr_q[DELAY_BITS-1:0] : cnt_q - DELAY_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED_EFF;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    // With ENABLE off the state is dead logic and the trigger simply follows reset.
    assign delay_trigger = rst & (!ENABLE || cnt_zero);

endmodule

// File: tb/tb_random_delay_generator.sv
// Directed bench for random_delay_generator (enabled and disabled) and mux_key lookup tables.
module tb_random_delay_generator;

    logic clk;
    logic rst;
    logic trig;
    logic trig_off;

    int checks;
    int failures;

    random_delay_generator u_dut (
        .clk           (clk),
        .rst           (rst),
        .delay_trigger (trig)
    );

    random_delay_generator #(
        .ENABLE (1'b0)
    ) u_dut_off (
        .clk           (clk),
        .rst           (rst),
        .delay_trigger (trig_off)
    );

    // mux_key instances: LSU extension table, shift table, default 1-bit table
    logic [31:0]  data;
    logic [2:0]   ext_key;
    logic [1:0]   sh_key;
    logic         sm_key;
    logic [174:0] ext_lut;
    logic [135:0] sh_lut;
    logic [3:0]   sm_lut;
    logic [31:0]  ext_out;
    logic [31:0]  sh_out;
    logic         sm_out;

    assign ext_lut = {3'b100, {16'h0, data[15:0]},
                      3'b011, {24'h0, data[7:0]},
                      3'b010, {{16{data[15]}}, data[15:0]},
                      3'b001, {{24{data[7]}}, data[7:0]},
                      3'b000, data};
    assign sh_lut  = {2'b11, {24'h0, data[31:24]},
                      2'b10, {16'h0, data[31:16]},
                      2'b01, {8'h0, data[31:8]},
                      2'b00, data};
    assign sm_lut  = data[3:0];

    mux_key #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u_ext (
        .out (ext_out), .key (ext_key), .lut (ext_lut)
    );
    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(32)) u_sh (
        .out (sh_out), .key (sh_key), .lut (sh_lut)
    );
    mux_key u_sm (
        .out (sm_out), .key (sm_key), .lut (sm_lut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          tbl;   // 0 = ext, 1 = shift, 2 = small
        logic [31:0] d;
        logic [2:0]  k;
        logic [31:0] exp;
    } mux_vec_t;

    mux_vec_t    vecs [15];
    logic [17:0] exp_seq;
    int          highs;
    int          low_run;
    int          max_low;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        data     = '0;
        ext_key  = '0;
        sh_key   = '0;
        sm_key   = 1'b0;

        vecs[0]  = '{0, 32'h0000_0080, 3'b001, 32'hFFFF_FF80};
        vecs[1]  = '{0, 32'h0000_0080, 3'b011, 32'h0000_0080};
        vecs[2]  = '{0, 32'h0000_0080, 3'b111, 32'h0000_0000};
        vecs[3]  = '{0, 32'h0000_0080, 3'b010, 32'h0000_0080};
        vecs[4]  = '{0, 32'h1234_8001, 3'b010, 32'hFFFF_8001};
        vecs[5]  = '{0, 32'h1234_8001, 3'b100, 32'h0000_8001};
        vecs[6]  = '{0, 32'h1234_8001, 3'b000, 32'h1234_8001};
        vecs[7]  = '{1, 32'hAABB_CCDD, 3'b010, 32'h0000_AABB};
        vecs[8]  = '{1, 32'hAABB_CCDD, 3'b011, 32'h0000_00AA};
        vecs[9]  = '{1, 32'hAABB_CCDD, 3'b000, 32'hAABB_CCDD};
        vecs[10] = '{1, 32'hAABB_CCDD, 3'b001, 32'h00AA_BBCC};
        vecs[11] = '{2, 32'h0000_0009, 3'b000, 32'h0000_0001};
        vecs[12] = '{2, 32'h0000_0009, 3'b001, 32'h0000_0000};
        vecs[13] = '{2, 32'h0000_000E, 3'b001, 32'h0000_0001};  // duplicate keys OR together
        vecs[14] = '{2, 32'h0000_000E, 3'b000, 32'h0000_0000};

        // Trigger high in cycles 0, 2, 7, 14, 17 after release (SEED 01, 3-bit gaps)
        exp_seq = 18'b10_0100_0000_1000_0101;

        for (int i = 0; i < 15; i++) begin
            data    = vecs[i].d;
            ext_key = vecs[i].k;
            sh_key  = vecs[i].k[1:0];
            sm_key  = vecs[i].k[0];
            #1;
            case (vecs[i].tbl)
                0:       check($sformatf("mux_ext[%0d]", i), ext_out, vecs[i].exp);
                1:       check($sformatf("mux_shift[%0d]", i), sh_out, vecs[i].exp);
                default: check($sformatf("mux_small[%0d]", i), {31'h0, sm_out}, vecs[i].exp);
            endcase
        end

        // Held in reset with the clock running
        repeat (4) begin
            @(negedge clk);
            check("reset_trig", {31'h0, trig}, 32'h0);
            check("reset_trig_off", {31'h0, trig_off}, 32'h0);
        end

        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("seq_cycle%0d", i), {31'h0, trig}, {31'h0, exp_seq[i]});
            check($sformatf("off_cycle%0d", i), {31'h0, trig_off}, 32'h1);
        end

        // Restart, then assert reset mid-cycle while the trigger is high
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("reset_restart", {31'h0, trig}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rerun_cycle%0d", i), {31'h0, trig}, {31'h0, exp_seq[i]});
        end
        #2 rst = 1'b0;
        #1;
        check("async_drop", {31'h0, trig}, 32'h0);
        check("async_drop_off", {31'h0, trig_off}, 32'h0);

        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("determ_cycle%0d", i), {31'h0, trig}, {31'h0, exp_seq[i]});
        end

        // Long run: gap bound and duty cycle
        highs   = 0;
        low_run = 0;
        max_low = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (trig) begin
                highs++;
                low_run = 0;
            end else begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end
        end
        check("long_max_low_run_le7", {31'h0, max_low <= 7}, 32'h1);
        check("long_duty_15_40pct", {31'h0, (highs >= 1500) && (highs <= 4000)}, 32'h1);
        check("long_off_high", {31'h0, trig_off}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
